input_debouncer: RTL
====================

Name: input_debouncer

Overview:
- Conditions a raw, asynchronous, bouncy input (push-button or switch) into a clean, clock-synchronous level.
- Drives the D input of the edge-triggered flip-flop stage directly downstream.
- Also emits single-cycle rise/fall pulses and keeps a wrapping count of accepted rising edges.
- Removes the setup/hold hazards and glitches that would otherwise reach the flop's d pin.

Parameters:
- STABLE, 4, number of consecutive synchronized samples at the new value required to accept a change; legal range 2..255.
- CW, 8, internal stability-counter width; must satisfy 2^CW > STABLE.

Ports:
- c  input  1  clock; all state updates on the rising edge.
- rn  input  1  reset, asynchronous, active-low.
- d_raw  input  1  raw asynchronous input.
- d_clean  output  1  debounced level; feeds downstream flop d.
- rise  output  1  one-cycle pulse when d_clean goes 0->1.
- fall  output  1  one-cycle pulse when d_clean goes 1->0.
- count  output  8  number of accepted rising edges, modulo 256.

Behaviour:
- Reset (rn=0, asynchronous, no clock needed):
  - sync stages s1=0, s2=0; state=LOW; cnt=0.
  - d_clean=0, rise=0, fall=0, count=0.
  - Deassertion of rn takes effect at the next rising edge of c.
- Synchronizer: two-stage chain, s1<=d_raw, s2<=s1. The FSM uses only s2.
- FSM states: LOW, WAIT_HI, HIGH, WAIT_LO. All transitions on the rising edge of c.
  - LOW: s2=1 -> WAIT_HI, cnt=1; else stay, cnt=0.
  - WAIT_HI: s2=0 -> LOW, cnt=0 (glitch rejected, no pulse).
  - WAIT_HI: s2=1 and cnt==STABLE-1 -> HIGH, d_clean=1, rise=1, count=count+1, cnt=0.
  - WAIT_HI: s2=1 otherwise -> cnt=cnt+1.
  - HIGH and WAIT_LO: mirror images of LOW and WAIT_HI. Commit sets d_clean=0 and fall=1; count is unchanged.
- Pulses:
  - rise and fall are registered, high for exactly one cycle (the cycle after the commit edge).
  - Never both high in the same cycle.
- Latency: if d_raw changes between edges k-1 and k and then stays stable, d_clean changes at edge k+STABLE+1 (for STABLE=4: k+5).
- Reject window: a new value that persists for fewer than STABLE FSM samples never reaches d_clean.
- count wraps 255->0 without a flag.
- Reset mid-WAIT: all progress is lost. After release, a full STABLE run is needed again.
- The d_clean, rise and fall outputs are driven directly from flops, with no combinational path from d_raw.

Test Plan:
- Reset: rn=0 with d_raw=1 toggling -> d_clean=0, rise=0, fall=0, count=0 throughout; all asynchronous, with no clock edge required.
- Clean rise (STABLE=4, 20-unit clock period): d_raw 0->1 between edges 0 and 1 and held -> d_clean=1 from edge 6; rise=1 only between edges 6 and 7; count=1.
- Glitch: d_raw high across edges 1-2 only, then low -> FSM reaches WAIT_HI with cnt=2, then returns to LOW; d_clean stays 0, no rise, count=0.
- Bounce then settle: d_raw toggles 1,0,1,0 on consecutive cycles, then holds 1 -> exactly one rise, 5 edges after the final transition; count increments by 1.
- Clean fall: from HIGH, d_raw 1->0 held -> d_clean=0 five edges later; fall pulse for one cycle; count unchanged.
- Wrap and reset mid-operation:
  - 256 accepted presses -> count returns to 0.
  - rn pulsed low while in WAIT_HI with cnt=2 -> immediate all-zero outputs; after release, d_clean rises only after a full STABLE+2 edges of stable high.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw bouncy input source and the debouncer.
//   d_raw   : raw asynchronous input (source -> debouncer)
//   d_clean : debounced level, registered
//   rise    : one-cycle pulse on an accepted 0->1 change
//   fall    : one-cycle pulse on an accepted 1->0 change
//   count   : accepted rising edges, modulo 256
interface input_debouncer_if;
    logic       d_raw;
    logic       d_clean;
    logic       rise;
    logic       fall;
    logic [7:0] count;

    modport master (
        output d_raw,
        input  d_clean,
        input  rise,
        input  fall,
        input  count
    );

    modport slave (
        input  d_raw,
        output d_clean,
        output rise,
        output fall,
        output count
    );
endinterface

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a clean clock-synchronous level.
// A two-flop synchronizer feeds a four-state FSM; a change is accepted only
// after STABLE consecutive synchronized samples at the new value.
// Ports:
//   c    : clock, rising edge
//   rn   : asynchronous active-low reset
//   bus  : slave side of input_debouncer_if (d_raw in; d_clean/rise/fall/count out)
module input_debouncer #(
    parameter int unsigned STABLE = 4,
    parameter int unsigned CW     = 8
) (
    input  logic               c,
    input  logic               rn,
    input_debouncer_if.slave   bus
);

    localparam logic [1:0] LOW     = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] HIGH    = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

    logic          s1;
    logic          s2;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          d_clean_q;
    logic          d_clean_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;
    logic [7:0]    count_q;
    logic [7:0]    count_d;

    // Two-stage synchronizer; only s2 is used by the FSM.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.d_raw;
            s2 <= s1;
        end
    end

    // State, stability counter and all output registers.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            d_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_clean_q <= d_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            count_q   <= count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_clean_d = d_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        count_d   = count_q;
        case (state_q)
            LOW: begin
                if (s2) begin
                    state_d = WAIT_HI;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d   = HIGH;
                    cnt_d     = '0;
                    d_clean_d = 1'b1;
                    rise_d    = 1'b1;
                    count_d   = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_d = WAIT_LO;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d   = LOW;
                    cnt_d     = '0;
                    d_clean_d = 1'b0;
                    fall_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.d_clean = d_clean_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.count   = count_q;

endmodule
